// File: rtl/pipelined_instruction_decoder.sv
// rtl/pipelined_instruction_decoder.sv - registered DLX decode stage with valid/ready handshake
// Decodes R/I/J fields, enables and immediates; counts accepted illegal opcodes.
module pipelined_instruction_decoder #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH        = 32,
    parameter int PC_WIDTH          = 32,
    parameter int LINK_REG          = 31,
    parameter int ILL_CNT_WIDTH     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_in,
    input  logic                         inst_valid_in,
    output logic                         inst_ready_out,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
    input  logic [PC_WIDTH-1:0]          pc_in,
    output logic                         dec_valid_out,
    input  logic                         dec_ready_in,
    output logic [PC_WIDTH-1:0]          pc_out,
    output logic [1:0]                   inst_type_out,
    output logic [5:0]                   opcode_out,
    output logic [10:0]                  func_out,
    output logic [REG_ADDR_WIDTH-1:0]    read_address1_out,
    output logic [REG_ADDR_WIDTH-1:0]    read_address2_out,
    output logic                         read1_en_out,
    output logic                         read2_en_out,
    output logic [REG_ADDR_WIDTH-1:0]    write_address_out,
    output logic                         write_en_out,
    output logic [DATA_WIDTH-1:0]        immediate_out,
    output logic                         illegal_out,
    output logic [ILL_CNT_WIDTH-1:0]     illegal_count_out
);

    typedef struct packed {
        logic [1:0]                typ;
        logic [5:0]                opcode;
        logic [10:0]               func;
        logic [REG_ADDR_WIDTH-1:0] ra1;
        logic [REG_ADDR_WIDTH-1:0] ra2;
        logic                      r1en;
        logic                      r2en;
        logic [REG_ADDR_WIDTH-1:0] wa;
        logic                      we;
        logic [DATA_WIDTH-1:0]     imm;
        logic                      ill;
    } dec_t;

    localparam logic [REG_ADDR_WIDTH-1:0] LINK_ADDR = REG_ADDR_WIDTH'(LINK_REG);

    dec_t                     dec_c, dec_q, dec_d;
    logic                     valid_q, valid_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic [ILL_CNT_WIDTH-1:0] ill_cnt_q, ill_cnt_d;
    logic [5:0]               op;
    logic                     accept;

    assign op = instruction_in[31:26];

    always_comb begin
        dec_c        = '0;
        dec_c.opcode = op;
        case (op)
            6'h00: begin
                dec_c.typ  = 2'b01;
                dec_c.ra1  = instruction_in[25:21];
                dec_c.ra2  = instruction_in[20:16];
                dec_c.r1en = 1'b1;
                dec_c.r2en = 1'b1;
                dec_c.wa   = instruction_in[15:11];
                dec_c.func = instruction_in[10:0];
            end
            6'h01, 6'h3F: dec_c.ill = 1'b1;
            6'h02, 6'h03: begin
                dec_c.typ = 2'b11;
                dec_c.imm = DATA_WIDTH'($signed(instruction_in[25:0]));
                if (op == 6'h03) dec_c.wa = LINK_ADDR;
            end
            default: begin
                dec_c.typ  = 2'b10;
                dec_c.ra1  = instruction_in[25:21];
                dec_c.r1en = 1'b1;
                if (op == 6'h09 || op == 6'h0B || op == 6'h0C || op == 6'h0D || op == 6'h0E)
                    dec_c.imm = DATA_WIDTH'(instruction_in[15:0]);
                else
                    dec_c.imm = DATA_WIDTH'($signed(instruction_in[15:0]));
                // Stores (0x28..0x2F) read their data register through port 2 and write nothing.
                if (op[5:3] == 3'b101) begin
                    dec_c.ra2  = instruction_in[20:16];
                    dec_c.r2en = 1'b1;
                end else if (op == 6'h13) begin
                    dec_c.wa = LINK_ADDR;
                end else if (op != 6'h04 && op != 6'h05 && op != 6'h12) begin
                    dec_c.wa = instruction_in[20:16];
                end
            end
        endcase
        dec_c.we = (dec_c.wa != '0);
    end

    assign inst_ready_out = !rst && !flush_in && (!valid_q || dec_ready_in);
    assign accept         = inst_valid_in && inst_ready_out;

    always_comb begin
        dec_d     = dec_q;
        valid_d   = valid_q;
        pc_d      = pc_q;
        ill_cnt_d = ill_cnt_q;
        if (flush_in) begin
            valid_d = 1'b0;
        end else if (accept) begin
            dec_d   = dec_c;
            valid_d = 1'b1;
            pc_d    = pc_in;
            if (dec_c.ill && (ill_cnt_q != '1)) ill_cnt_d = ill_cnt_q + 1'b1;
        end else if (dec_ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q     <= '0;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            ill_cnt_q <= '0;
        end else begin
            dec_q     <= dec_d;
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign dec_valid_out     = valid_q;
    assign pc_out            = pc_q;
    assign inst_type_out     = dec_q.typ;
    assign opcode_out        = dec_q.opcode;
    assign func_out          = dec_q.func;
    assign read_address1_out = dec_q.ra1;
    assign read_address2_out = dec_q.ra2;
    assign read1_en_out      = dec_q.r1en;
    assign read2_en_out      = dec_q.r2en;
    assign write_address_out = dec_q.wa;
    assign write_en_out      = dec_q.we;
    assign immediate_out     = dec_q.imm;
    assign illegal_out       = dec_q.ill;
    assign illegal_count_out = ill_cnt_q;

endmodule
